// File: rtl/split4wsign_if.sv
// Request/result bundle for split4wsign: target/base request handshake plus
// the base and three sign-magnitude contributions on the result side.
interface split4wsign_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] target;
  logic [15:0] base;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] c0;
  logic [15:0] c1;
  logic [15:0] c2;
  logic [15:0] c3;
  logic        c1_sgn;
  logic        c2_sgn;
  logic        c3_sgn;
  logic        exact;

  modport master (
    output in_valid, target, base, out_ready,
    input  in_ready, out_valid, c0, c1, c2, c3, c1_sgn, c2_sgn, c3_sgn, exact
  );

  modport slave (
    input  in_valid, target, base, out_ready,
    output in_ready, out_valid, c0, c1, c2, c3, c1_sgn, c2_sgn, c3_sgn, exact
  );
endinterface

// File: rtl/split4wsign.sv
// Splits a 16-bit PWM target into base + three rounded sign-magnitude
// contributions (coarse/medium/fine), one rounding step per cycle.
module split4wsign #(
  parameter int S1 = 12,
  parameter int S2 = 6,
  parameter int S3 = 0
) (
  input logic         clk,
  input logic         rst_n,
  split4wsign_if.slave bus
);
  localparam logic [4:0] SH1 = 5'(S1);
  localparam logic [4:0] SH2 = 5'(S2);
  localparam logic [4:0] SH3 = 5'(S3);

  typedef enum logic [2:0] {IDLE, STEP1, STEP2, STEP3, DONE} state_t;

  state_t             state_reg, state_next;
  logic signed [17:0] r_reg, r_next;
  logic [15:0]        c0_reg;
  logic [15:0]        mag_reg [3];
  logic [2:0]         sgn_reg;
  logic               exact_reg;
  logic               in_ready_reg;
  logic               out_valid_reg;

  logic [4:0]  shift;
  logic        step_en;
  logic [1:0]  step_idx;
  logic [15:0] diff;
  logic [17:0] mag;
  logic [17:0] half;
  logic [17:0] mask;
  logic [17:0] q;

  // Per-step quantisation shift and which contribution register is written.
  always_comb begin
    shift    = '0;
    step_en  = 1'b0;
    step_idx = 2'd0;
    case (state_reg)
      STEP1: begin shift = SH1; step_en = 1'b1; step_idx = 2'd0; end
      STEP2: begin shift = SH2; step_en = 1'b1; step_idx = 2'd1; end
      STEP3: begin shift = SH3; step_en = 1'b1; step_idx = 2'd2; end
      default: ;
    endcase
  end

  // Round |r| to nearest multiple of 2^shift, ties away from zero.
  assign diff = bus.target - bus.base;
  assign mag  = r_reg[17] ? 18'(-r_reg) : 18'(r_reg);
  assign half = (shift == 5'd0) ? 18'd0 : (18'd1 << (shift - 5'd1));
  assign mask = ~((18'd1 << shift) - 18'd1);
  assign q    = (mag + half) & mask;

  always_comb begin
    state_next = state_reg;
    r_next     = r_reg;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          state_next = STEP1;
          r_next     = {{2{diff[15]}}, diff};
        end
      end
      STEP1: state_next = STEP2;
      STEP2: state_next = STEP3;
      STEP3: state_next = DONE;
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (step_en) begin
      r_next = r_reg[17] ? (r_reg + $signed(q)) : (r_reg - $signed(q));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      r_reg         <= '0;
      c0_reg        <= '0;
      exact_reg     <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      r_reg         <= r_next;
      in_ready_reg  <= (state_next == IDLE);
      out_valid_reg <= (state_next == DONE);
      if (state_reg == IDLE && bus.in_valid) c0_reg <= bus.base;
      if (state_reg == STEP3) exact_reg <= (r_next == 18'sd0);
    end
  end

  // Each contribution is only rewritten in its own step, so results hold
  // after the handshake until the next transaction overwrites them.
  for (genvar gi = 0; gi < 3; gi++) begin : g_contrib
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mag_reg[gi] <= '0;
        sgn_reg[gi] <= 1'b0;
      end else if (step_en && step_idx == 2'(gi)) begin
        mag_reg[gi] <= q[15:0];
        sgn_reg[gi] <= r_reg[17] && (q != 18'd0);
      end
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.c0        = c0_reg;
  assign bus.c1        = mag_reg[0];
  assign bus.c2        = mag_reg[1];
  assign bus.c3        = mag_reg[2];
  assign bus.c1_sgn    = sgn_reg[0];
  assign bus.c2_sgn    = sgn_reg[1];
  assign bus.c3_sgn    = sgn_reg[2];
  assign bus.exact     = exact_reg;
endmodule

// File: tb/tb_split4wsign.sv
// Randomised and directed bench for split4wsign: two instances (S3=0, S3=2)
// driven with identical requests and compared against an arithmetic model.
module tb_split4wsign;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  split4wsign_if ifa ();
  split4wsign_if ifb ();

  split4wsign #(.S1(12), .S2(6), .S3(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  split4wsign #(.S1(12), .S2(6), .S3(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: signed shortest-path residual, rounded step by step with
  // integer division.
  function automatic void ref_model(input logic [15:0] t, input logic [15:0] b,
                                    input int s1, input int s2, input int s3,
                                    output logic [47:0] mags, output logic [2:0] sgns,
                                    output logic ex);
    logic signed [15:0] d;
    int r, m, q, s, p;
    d = t - b;
    r = d;
    mags = '0;
    sgns = '0;
    for (int k = 0; k < 3; k++) begin
      s = (k == 0) ? s1 : (k == 1) ? s2 : s3;
      m = (r < 0) ? -r : r;
      if (s == 0) q = m;
      else begin
        p = 1 << s;
        q = ((m + p / 2) / p) * p;
      end
      mags[k*16 +: 16] = q[15:0];
      sgns[k] = (r < 0) && (q != 0);
      r = (r < 0) ? r + q : r - q;
    end
    ex = (r == 0);
  endfunction

  function automatic logic [15:0] rebuild(input logic [15:0] c0, input logic [15:0] c1,
                                          input logic [15:0] c2, input logic [15:0] c3,
                                          input logic s1, input logic s2, input logic s3);
    logic [15:0] acc;
    acc = c0;
    acc = s1 ? acc - c1 : acc + c1;
    acc = s2 ? acc - c2 : acc + c2;
    acc = s3 ? acc - c3 : acc + c3;
    return acc;
  endfunction

  task automatic drive_idle();
    ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
    ifa.out_ready = 1'b0; ifb.out_ready = 1'b0;
  endtask

  // One full transaction on both instances with all result checks.
  task automatic run_txn(input logic [15:0] t, input logic [15:0] b, input bit verbose);
    int wait_cnt, lat;
    logic [47:0] ma, mb;
    logic [2:0]  sa, sb;
    logic        ea, eb;
    logic [15:0] d;
    wait_cnt = 0;
    while (!(ifa.in_ready && ifb.in_ready) && wait_cnt < 20) begin
      @(posedge clk); #1; wait_cnt++;
    end
    check("in_ready_wait", 32'(ifa.in_ready && ifb.in_ready), 32'd1);
    ifa.target = t; ifa.base = b; ifa.in_valid = 1'b1;
    ifb.target = t; ifb.base = b; ifb.in_valid = 1'b1;
    @(posedge clk); #1;
    ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
    lat = 0;
    while (!ifa.out_valid && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    check("latency", 32'(lat), 32'd3);
    check("b_out_valid", 32'(ifb.out_valid), 32'd1);

    ref_model(t, b, 12, 6, 0, ma, sa, ea);
    ref_model(t, b, 12, 6, 2, mb, sb, eb);
    d = t - b;
    check("a_c0", 32'(ifa.c0), 32'(b));
    check("a_mags", 32'({ifa.c1, ifa.c2} ^ 32'(ifa.c3)), 32'({ma[15:0], ma[31:16]} ^ 32'(ma[47:32])));
    check("a_c3", 32'(ifa.c3), 32'(ma[47:32]));
    check("a_sgns", 32'({ifa.c3_sgn, ifa.c2_sgn, ifa.c1_sgn}), 32'(sa));
    check("a_exact", 32'(ifa.exact), 32'd1);
    check("a_sum", 32'(rebuild(ifa.c0, ifa.c1, ifa.c2, ifa.c3, ifa.c1_sgn, ifa.c2_sgn, ifa.c3_sgn)), 32'(t));
    check("b_c1c2", 32'({ifb.c1, ifb.c2}), 32'({mb[15:0], mb[31:16]}));
    check("b_c3", 32'(ifb.c3), 32'(mb[47:32]));
    check("b_sgns", 32'({ifb.c3_sgn, ifb.c2_sgn, ifb.c1_sgn}), 32'(sb));
    check("b_exact", 32'(ifb.exact), 32'(d[1:0] == 2'b00));
    if (ifb.exact)
      check("b_sum", 32'(rebuild(ifb.c0, ifb.c1, ifb.c2, ifb.c3, ifb.c1_sgn, ifb.c2_sgn, ifb.c3_sgn)), 32'(t));
    if (verbose)
      $display("[TB] txn target=%h base=%h -> c1=%h/%0d c2=%h/%0d c3=%h/%0d exact=%0d",
               t, b, ifa.c1, ifa.c1_sgn, ifa.c2, ifa.c2_sgn, ifa.c3, ifa.c3_sgn, ifa.exact);

    ifa.out_ready = 1'b1; ifb.out_ready = 1'b1;
    @(posedge clk); #1;
    ifa.out_ready = 1'b0; ifb.out_ready = 1'b0;
    check("out_valid_drop", 32'(ifa.out_valid), 32'd0);
    check("in_ready_after", 32'(ifa.in_ready), 32'd1);
  endtask

  initial begin
    int stable_err, lat, last_rise, gaps_bad, rises;
    logic [15:0] hold_c1, hold_c2;
    logic prev_ov;
    drive_idle();
    ifa.target = '0; ifa.base = '0; ifb.target = '0; ifb.base = '0;
    #12;
    check("rst_in_ready", 32'(ifa.in_ready), 32'd1);
    check("rst_out_valid", 32'(ifa.out_valid), 32'd0);
    check("rst_c1", 32'(ifa.c1), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    run_txn(16'h1A37, 16'h1000, 1'b1);
    check("d1_c1", 32'({ifa.c1, 15'd0, ifa.c1_sgn}), 32'({16'h1000, 16'd0}));
    check("d1_c2", 32'({ifa.c2, 15'd0, ifa.c2_sgn}), 32'({16'h05C0, 16'd1}));
    check("d1_c3", 32'({ifa.c3, 15'd0, ifa.c3_sgn}), 32'({16'h0009, 16'd1}));
    check("d1_exact", 32'(ifa.exact), 32'd1);
    run_txn(16'h0010, 16'hFFF0, 1'b1);
    check("d2_c1", 32'({ifa.c1, 15'd0, ifa.c1_sgn}), 32'd0);
    check("d2_c2", 32'({ifa.c2, 15'd0, ifa.c2_sgn}), 32'({16'h0040, 16'd0}));
    check("d2_c3", 32'({ifa.c3, 15'd0, ifa.c3_sgn}), 32'({16'h0020, 16'd1}));
    run_txn(16'h8000, 16'h0000, 1'b1);
    check("d3_c1", 32'({ifa.c1, 15'd0, ifa.c1_sgn}), 32'({16'h8000, 16'd1}));
    check("d3_c2c3", 32'({ifa.c2, ifa.c3}), 32'd0);
    check("d3_sgn23", 32'({ifa.c2_sgn, ifa.c3_sgn}), 32'd0);
    check("d3_exact", 32'(ifa.exact), 32'd1);

    // Back-pressure: result must hold with out_ready low
    ifa.target = 16'h4321; ifa.base = 16'h0123; ifa.in_valid = 1'b1;
    ifb.target = 16'h4321; ifb.base = 16'h0123; ifb.in_valid = 1'b1;
    @(posedge clk); #1;
    drive_idle();
    lat = 0;
    while (!ifa.out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
    check("bp_latency", 32'(lat), 32'd3);
    hold_c1 = ifa.c1; hold_c2 = ifa.c2;
    stable_err = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!ifa.out_valid || ifa.in_ready || ifa.c1 !== hold_c1 || ifa.c2 !== hold_c2) stable_err++;
    end
    check("bp_stable", 32'(stable_err), 32'd0);
    ifa.out_ready = 1'b1; ifb.out_ready = 1'b1;
    @(posedge clk); #1;
    drive_idle();
    check("bp_in_ready", 32'(ifa.in_ready), 32'd1);
    check("bp_out_valid", 32'(ifa.out_valid), 32'd0);
    $display("[TB] txn back-pressure target=4321 base=0123 held 10 cycles");

    // Streaming throughput: one result per 5 cycles
    ifa.target = 16'h2222; ifa.base = 16'h1111; ifa.in_valid = 1'b1; ifa.out_ready = 1'b1;
    ifb.target = 16'h2222; ifb.base = 16'h1111; ifb.in_valid = 1'b1; ifb.out_ready = 1'b1;
    prev_ov = 1'b0; last_rise = -1; gaps_bad = 0; rises = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      if (ifa.out_valid && !prev_ov) begin
        if (last_rise >= 0 && cyc - last_rise != 5) gaps_bad++;
        last_rise = cyc; rises++;
      end
      prev_ov = ifa.out_valid;
    end
    check("stream_gaps", 32'(gaps_bad), 32'd0);
    check("stream_count", 32'(rises >= 7), 32'd1);
    ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    drive_idle();
    $display("[TB] txn streaming %0d results", rises);

    // Reset in the middle of STEP2
    ifa.target = 16'h7777; ifa.base = 16'h0001; ifa.in_valid = 1'b1;
    ifb.target = 16'h7777; ifb.base = 16'h0001; ifb.in_valid = 1'b1;
    @(posedge clk); #1;
    drive_idle();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(ifa.in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(ifa.out_valid), 32'd0);
    check("mid_rst_outs", 32'({ifa.c0, ifa.c1} | {ifa.c2, ifa.c3}), 32'd0);
    check("mid_rst_flags", 32'({ifa.c1_sgn, ifa.c2_sgn, ifa.c3_sgn, ifa.exact}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("post_rst_idle", 32'({ifa.out_valid, ifa.in_ready}), 32'b01);
    $display("[TB] txn reset mid-STEP2");

    // Random vectors
    for (int n = 0; n < 10000; n++)
      run_txn(16'($urandom), 16'($urandom), 1'b0);
    $display("[TB] txn random 10000 vectors done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
